// File: rtl/fifo_stream_driver_if.sv
// Handshake and byte-source bundle for fifo_stream_driver.
// The driver reads its byte stream through rd_addr/rd_data/file_len instead of a host file.
interface fifo_stream_driver_if #(
  parameter int unsigned WIDTH = 8
);
  logic             ready;
  logic             wr_en;
  logic [WIDTH-1:0] out;
  logic [31:0]      address;
  logic             done;
  logic             eof_seen;
  // Byte source: rd_data[8*i +: 8] is source byte rd_addr+i; bytes at or past file_len are invalid.
  logic [31:0]      file_len;
  logic [31:0]      rd_addr;
  logic [WIDTH-1:0] rd_data;

  modport master (
    input  ready, file_len, rd_data,
    output wr_en, out, address, done, eof_seen, rd_addr
  );

  modport slave (
    output ready, file_len, rd_data,
    input  wr_en, out, address, done, eof_seen, rd_addr
  );
endinterface

// File: rtl/fifo_stream_driver.sv
// Streams a byte source into a valid/ready sink one WIDTH-bit word per accepted beat,
// with byte-order selection, valid throttling, EOF stop/rewind and a sticky done flag.
module fifo_stream_driver #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned RESET_TIME    = 10,
  parameter int unsigned END_ADDRESS   = 32'd2147483640,
  parameter bit          BIG_ENDIAN    = 1'b0,
  parameter int unsigned THROTTLE_MODE = 0,
  parameter int unsigned GAP_PERIOD    = 4,
  parameter int unsigned GAP_LEN       = 1,
  parameter int unsigned DUTY          = 128,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter bit          EOF_MODE      = 1'b0
) (
  input logic                  clk,
  input logic                  reset,
  fifo_stream_driver_if.master bus
);

  localparam int unsigned NumBytes = WIDTH / 8;

  typedef enum logic [2:0] {StHold, StLoad, StPresent, StGap, StDone} state_e;

  state_e           state_q, state_d;
  logic [31:0]      rst_cnt_q, rst_cnt_d;
  logic [31:0]      pos_q, pos_d;
  logic [31:0]      address_q, address_d;
  logic [31:0]      beat_cnt_q, beat_cnt_d;
  logic [31:0]      gap_cnt_q, gap_cnt_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             eof_seen_q, eof_seen_d;

  logic             lfsr_fb, lfsr_hit;
  logic             eof_first, eof_pad, fetch_end;
  logic [31:0]      fetch_addr;
  logic [WIDTH-1:0] fetch_word;
  logic [7:0]       fetch_byte;
  logic             fetch_go, beat_acc;

  assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_hit = ({24'd0, lfsr_q[7:0]} < DUTY);

  // Word fetch: with rewind enabled an exhausted source is re-read from byte 0 in the same edge.
  always_comb begin
    eof_first  = (pos_q >= bus.file_len);
    fetch_addr = (eof_first && EOF_MODE) ? 32'd0 : pos_q;
    fetch_end  = eof_first && (!EOF_MODE || (bus.file_len == 32'd0));
    eof_pad    = 1'b0;
    fetch_word = '0;
    fetch_byte = 8'h00;
    for (int unsigned i = 0; i < NumBytes; i++) begin
      if (fetch_addr + i < bus.file_len) begin
        fetch_byte = bus.rd_data[8*i +: 8];
      end else begin
        fetch_byte = 8'h00;
        eof_pad    = 1'b1;
      end
      if (BIG_ENDIAN) begin
        fetch_word[WIDTH-8-8*i +: 8] = fetch_byte;
      end else begin
        fetch_word[8*i +: 8] = fetch_byte;
      end
    end
  end

  assign bus.rd_addr = fetch_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StHold;
      rst_cnt_q  <= '0;
      pos_q      <= '0;
      address_q  <= '0;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
      lfsr_q     <= LFSR_SEED;
      out_q      <= '0;
      eof_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      pos_q      <= pos_d;
      address_q  <= address_d;
      beat_cnt_q <= beat_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      lfsr_q     <= lfsr_d;
      out_q      <= out_d;
      eof_seen_q <= eof_seen_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    pos_d      = pos_q;
    address_d  = address_q;
    beat_cnt_d = beat_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    out_d      = out_q;
    eof_seen_d = eof_seen_q;
    lfsr_d     = (state_q == StHold) ? lfsr_q : {lfsr_q[14:0], lfsr_fb};
    fetch_go   = 1'b0;
    beat_acc   = 1'b0;

    unique case (state_q)
      StHold: begin
        if (rst_cnt_q == RESET_TIME) begin
          state_d = StLoad;
        end else begin
          rst_cnt_d = rst_cnt_q + 32'd1;
        end
      end
      StLoad: fetch_go = 1'b1;
      StPresent: begin
        if (bus.ready) begin
          address_d = address_q + 32'd1;
          if (address_q + 32'd1 == END_ADDRESS) begin
            state_d = StDone;
          end else begin
            fetch_go = 1'b1;
            beat_acc = 1'b1;
          end
        end
      end
      StGap: begin
        if (THROTTLE_MODE == 1) begin
          if (gap_cnt_q + 32'd1 >= GAP_LEN) begin
            state_d = StPresent;
          end else begin
            gap_cnt_d = gap_cnt_q + 32'd1;
          end
        end else if (THROTTLE_MODE != 2 || lfsr_hit) begin
          state_d = StPresent;
        end
      end
      default: ;
    endcase

    // A fetch also carries the throttle decision for the word it loads.
    if (fetch_go) begin
      if (eof_first || eof_pad) begin
        eof_seen_d = 1'b1;
      end
      if (fetch_end) begin
        state_d = StDone;
      end else begin
        out_d     = fetch_word;
        pos_d     = fetch_addr + NumBytes;
        gap_cnt_d = '0;
        state_d   = StPresent;
        if (THROTTLE_MODE == 1 && beat_acc) begin
          if (beat_cnt_q + 32'd1 >= GAP_PERIOD) begin
            beat_cnt_d = '0;
            state_d    = StGap;
          end else begin
            beat_cnt_d = beat_cnt_q + 32'd1;
          end
        end else if (THROTTLE_MODE == 2 && !lfsr_hit) begin
          state_d = StGap;
        end
      end
    end
  end

  always_comb begin
    bus.wr_en = 1'b0;
    bus.done  = 1'b0;
    unique case (state_q)
      StPresent: bus.wr_en = 1'b1;
      StDone:    bus.done  = 1'b1;
      default:   ;
    endcase
  end

  assign bus.out      = out_q;
  assign bus.address  = address_q;
  assign bus.eof_seen = eof_seen_q;

endmodule

// File: tb/tb_fifo_stream_driver.sv
// Drives six differently configured drivers from one clock and checks each stream
// against expected words built from the source bytes and configuration alone.
module tb_fifo_stream_driver;

  localparam int NK  = 6;
  localparam int RT0 = 3;
  localparam int RT1 = 0;
  localparam int RT2 = 2;
  localparam int RT3 = 1;
  localparam int RT4 = 4;
  localparam int RT5 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NK-1:0] rst_v = '1;
  logic [NK-1:0] rdy_v = '0;
  logic [NK-1:0] wr_v, done_v, eof_v;
  logic [31:0]   out_a  [NK];
  logic [31:0]   addr_a [NK];

  logic [7:0]  fmem [NK][32];
  int          flen [NK];
  int          nb_a [NK];
  bit          be_a [NK];
  bit          eofm_a [NK];
  int          endad_a [NK];
  int          rt_a [NK];

  logic [31:0] exp_w [NK][32];
  int          exp_n [NK];
  bit          exp_eof [NK];

  int          idx [NK];
  int          cyc [NK];
  int          ph [NK];
  bit          started [NK];
  bit          hold [NK];
  logic [31:0] prev_out [NK];

  int n_checks = 0;
  int n_fail   = 0;

  // Bytes past the end read back as 8'hEE so the driver's own padding is exercised.
  function automatic logic [31:0] file_word(input int k, input logic [31:0] a);
    logic [31:0] w;
    int          p;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      p = int'(a) + j;
      if (p >= 0 && p < flen[k] && p < 32) w[8*j +: 8] = fmem[k][p];
      else w[8*j +: 8] = 8'hEE;
    end
    return w;
  endfunction

  fifo_stream_driver_if #(.WIDTH(32)) if0 ();
  fifo_stream_driver_if #(.WIDTH(32)) if1 ();
  fifo_stream_driver_if #(.WIDTH(8))  if2 ();
  fifo_stream_driver_if #(.WIDTH(8))  if3 ();
  fifo_stream_driver_if #(.WIDTH(8))  if4 ();
  fifo_stream_driver_if #(.WIDTH(8))  if5 ();

  fifo_stream_driver #(.WIDTH(32), .RESET_TIME(RT0)) u0 (
    .clk(clk), .reset(rst_v[0]), .bus(if0));
  fifo_stream_driver #(.WIDTH(32), .RESET_TIME(RT1), .BIG_ENDIAN(1'b1)) u1 (
    .clk(clk), .reset(rst_v[1]), .bus(if1));
  fifo_stream_driver #(.WIDTH(8), .RESET_TIME(RT2), .THROTTLE_MODE(1), .GAP_PERIOD(2),
    .GAP_LEN(3)) u2 (.clk(clk), .reset(rst_v[2]), .bus(if2));
  fifo_stream_driver #(.WIDTH(8), .RESET_TIME(RT3), .EOF_MODE(1'b1), .END_ADDRESS(7)) u3 (
    .clk(clk), .reset(rst_v[3]), .bus(if3));
  fifo_stream_driver #(.WIDTH(8), .RESET_TIME(RT4), .THROTTLE_MODE(2), .DUTY(100)) u4 (
    .clk(clk), .reset(rst_v[4]), .bus(if4));
  fifo_stream_driver #(.WIDTH(8), .RESET_TIME(RT5)) u5 (
    .clk(clk), .reset(rst_v[5]), .bus(if5));

  assign if0.ready = rdy_v[0];
  assign if1.ready = rdy_v[1];
  assign if2.ready = rdy_v[2];
  assign if3.ready = rdy_v[3];
  assign if4.ready = rdy_v[4];
  assign if5.ready = rdy_v[5];
  assign if0.file_len = 32'(flen[0]);
  assign if1.file_len = 32'(flen[1]);
  assign if2.file_len = 32'(flen[2]);
  assign if3.file_len = 32'(flen[3]);
  assign if4.file_len = 32'(flen[4]);
  assign if5.file_len = 32'(flen[5]);
  assign if0.rd_data = file_word(0, if0.rd_addr);
  assign if1.rd_data = file_word(1, if1.rd_addr);
  assign if2.rd_data = 8'(file_word(2, if2.rd_addr));
  assign if3.rd_data = 8'(file_word(3, if3.rd_addr));
  assign if4.rd_data = 8'(file_word(4, if4.rd_addr));
  assign if5.rd_data = 8'(file_word(5, if5.rd_addr));

  assign wr_v   = {if5.wr_en, if4.wr_en, if3.wr_en, if2.wr_en, if1.wr_en, if0.wr_en};
  assign done_v = {if5.done, if4.done, if3.done, if2.done, if1.done, if0.done};
  assign eof_v  = {if5.eof_seen, if4.eof_seen, if3.eof_seen, if2.eof_seen, if1.eof_seen,
                   if0.eof_seen};
  assign out_a[0]  = if0.out;
  assign out_a[1]  = if1.out;
  assign out_a[2]  = 32'(if2.out);
  assign out_a[3]  = 32'(if3.out);
  assign out_a[4]  = 32'(if4.out);
  assign out_a[5]  = 32'(if5.out);
  assign addr_a[0] = if0.address;
  assign addr_a[1] = if1.address;
  assign addr_a[2] = if2.address;
  assign addr_a[3] = if3.address;
  assign addr_a[4] = if4.address;
  assign addr_a[5] = if5.address;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic string tag(input int k, input string s);
    return $sformatf("k%0d_%s", k, s);
  endfunction

  // Expected word stream: slice the byte list into words, pad past the end,
  // rewind or stop at end of data, and stop after the beat limit.
  task automatic build_model(input int k);
    int          pos;
    bit          eof;
    logic [31:0] w;
    logic [7:0]  b;
    pos      = 0;
    eof      = 1'b0;
    exp_n[k] = 0;
    while (exp_n[k] < endad_a[k] && exp_n[k] < 32) begin
      if (pos >= flen[k]) begin
        eof = 1'b1;
        if (!eofm_a[k] || flen[k] == 0) break;
        pos = 0;
      end
      w = '0;
      for (int j = 0; j < nb_a[k]; j++) begin
        if (pos + j < flen[k]) b = fmem[k][pos+j];
        else begin
          b   = 8'h00;
          eof = 1'b1;
        end
        if (be_a[k]) w = w | (32'(b) << (8 * (nb_a[k] - 1 - j)));
        else w = w | (32'(b) << (8 * j));
      end
      exp_w[k][exp_n[k]] = w;
      exp_n[k]++;
      pos += nb_a[k];
    end
    exp_eof[k] = eof;
  endtask

  task automatic reset_track(input int k);
    idx[k]     = 0;
    cyc[k]     = 0;
    ph[k]      = 0;
    started[k] = 1'b0;
    hold[k]    = 1'b0;
  endtask

  task automatic step(input int k);
    bit r;
    int m;
    cyc[k]++;
    if (started[k]) ph[k]++;
    if (!started[k] && wr_v[k]) begin
      started[k] = 1'b1;
      ph[k]      = 0;
      if (k != 4) check_eq(tag(k, "first_valid_latency"), 32'(cyc[k]), 32'(rt_a[k] + 2));
    end
    if (hold[k]) begin
      check_eq(tag(k, "valid_held"), 32'(wr_v[k]), 32'd1);
      check_eq(tag(k, "out_held"), out_a[k], prev_out[k]);
    end
    if (k == 2 && started[k] && idx[k] < exp_n[k])
      check_eq(tag(k, "gap_pattern"), 32'(wr_v[k]), 32'((ph[k] % 5) < 2));
    if (started[k] && !wr_v[k] && !done_v[k] && idx[k] < exp_n[k])
      check_eq(tag(k, "gap_out"), out_a[k], exp_w[k][idx[k]]);
    m = (cyc[k] - 1) % 4;
    case (k)
      0, 3, 4: r = ($urandom_range(0, 3) != 0);
      1:       r = (m == 0) || (m == 3);
      default: r = 1'b1;
    endcase
    rdy_v[k] = r;
    if (wr_v[k] && r) begin
      if (idx[k] < exp_n[k]) check_eq(tag(k, "data"), out_a[k], exp_w[k][idx[k]]);
      else check_eq(tag(k, "extra_beat"), 32'(idx[k]), 32'(exp_n[k]));
      idx[k]++;
    end
    hold[k]     = wr_v[k] && !r;
    prev_out[k] = out_a[k];
  endtask

  initial begin
    int cycles;
    bit mid_done;
    bit mid_rel;
    bit all_done;

    for (int k = 0; k < NK; k++) begin
      for (int j = 0; j < 32; j++) fmem[k][j] = 8'(j);
      endad_a[k] = 2147483640;
      eofm_a[k]  = 1'b0;
      be_a[k]    = 1'b0;
      nb_a[k]    = 1;
      reset_track(k);
      prev_out[k] = '0;
    end
    flen[0] = 10;
    flen[1] = 10;
    nb_a[0] = 4;
    nb_a[1] = 4;
    be_a[1] = 1'b1;
    flen[2] = 16;
    for (int j = 0; j < 16; j++) fmem[2][j] = 8'($urandom_range(0, 255));
    flen[3] = 3;
    fmem[3][0] = 8'hAA;
    fmem[3][1] = 8'hBB;
    fmem[3][2] = 8'hCC;
    eofm_a[3]  = 1'b1;
    endad_a[3] = 7;
    flen[4] = 20;
    for (int j = 0; j < 20; j++) fmem[4][j] = 8'($urandom_range(0, 255));
    flen[5] = 4;
    for (int j = 0; j < 4; j++) fmem[5][j] = 8'($urandom_range(0, 255));
    rt_a[0] = RT0;
    rt_a[1] = RT1;
    rt_a[2] = RT2;
    rt_a[3] = RT3;
    rt_a[4] = RT4;
    rt_a[5] = RT5;
    for (int k = 0; k < NK; k++) build_model(k);

    repeat (3) @(negedge clk);
    for (int k = 0; k < NK; k++) begin
      check_eq(tag(k, "reset_wr_en"), 32'(wr_v[k]), 32'd0);
      check_eq(tag(k, "reset_out"), out_a[k], 32'd0);
      check_eq(tag(k, "reset_address"), addr_a[k], 32'd0);
      check_eq(tag(k, "reset_done"), 32'(done_v[k]), 32'd0);
      check_eq(tag(k, "reset_eof_seen"), 32'(eof_v[k]), 32'd0);
    end
    rst_v = '0;

    cycles   = 0;
    mid_done = 1'b0;
    mid_rel  = 1'b0;
    all_done = 1'b0;
    while (!all_done && cycles < 1000) begin
      @(negedge clk);
      cycles++;
      for (int k = 0; k < NK; k++) if (!rst_v[k]) step(k);
      if (mid_rel) begin
        rst_v[5] = 1'b0;
        mid_rel  = 1'b0;
      end
      if (!mid_done && wr_v[5] && addr_a[5] == 32'd2) begin
        rst_v[5] = 1'b1;
        #1;
        check_eq("k5_mid_reset_wr_en", 32'(wr_v[5]), 32'd0);
        check_eq("k5_mid_reset_address", addr_a[5], 32'd0);
        mid_done = 1'b1;
        mid_rel  = 1'b1;
        reset_track(5);
      end
      all_done = mid_done && !mid_rel && (done_v == '1);
    end

    check_eq("k5_mid_reset_reached", 32'(mid_done), 32'd1);
    for (int k = 0; k < NK; k++) begin
      check_eq(tag(k, "final_done"), 32'(done_v[k]), 32'd1);
      check_eq(tag(k, "final_wr_en"), 32'(wr_v[k]), 32'd0);
      check_eq(tag(k, "final_eof_seen"), 32'(eof_v[k]), 32'(exp_eof[k]));
      check_eq(tag(k, "final_address"), addr_a[k], 32'(exp_n[k]));
      check_eq(tag(k, "beats_seen"), 32'(idx[k]), 32'(exp_n[k]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_stream_driver.md
# fifo_stream_driver

Simulation-only stream source that reads a binary file and drives it, one WIDTH-bit word per accepted beat, into a FIFO or DUT write port under a valid/ready handshake. It is the parametrised successor of the single-mode file write driver. It adds byte-order selection, valid throttling (periodic or pseudo-random), defined end-of-file handling with optional rewind, and a sticky completion flag. The whole body sits inside synthesis translate_off/on.

## Interface
Parameters:
- WIDTH, 8: data width in bits; must be a multiple of 8.
- FILE_NAME, "": binary input file, opened "rb" at time 0; open failure prints the path and calls $stop.
- RESET_TIME, 10: clock edges held idle after reset deassertion.
- END_ADDRESS, 2147483640: beat count at which the driver stops.
- BIG_ENDIAN, 0: 0 = first file byte lands in out[7:0]; 1 = first file byte lands in out[WIDTH-1:WIDTH-8].
- THROTTLE_MODE, 0: 0 = always valid; 1 = periodic gaps; 2 = LFSR-random gaps.
- GAP_PERIOD, 4: mode 1, number of accepted beats between gaps.
- GAP_LEN, 1: mode 1, idle cycles per gap (≥1).
- DUTY, 128: mode 2, present when lfsr[7:0] < DUTY (0..256).
- LFSR_SEED, 16'hACE1: mode 2 seed; must be non-zero.
- EOF_MODE, 0: 0 = stop at EOF; 1 = rewind the file and continue.

Ports:
- clk  in  1  clock; all activity on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ready  in  1  sink can accept the current word.
- wr_en  out  1  current word is valid.
- out  out  WIDTH  data word.
- address  out  32  number of beats accepted so far.
- done  out  1  sticky: the stream has finished.
- eof_seen  out  1  sticky: EOF has been reached at least once.

## Operation
- States: HOLD → LOAD → PRESENT ⇄ GAP → DONE.
- HOLD: reset counter counts edges up to RESET_TIME, then the FSM moves to LOAD.
- LOAD: reads WIDTH/8 bytes with $fgetc and arranges them into out according to BIG_ENDIAN. It then runs the throttle decision and goes to PRESENT or GAP.
- PRESENT: wr_en=1. Beat accepted on an edge with wr_en & ready:
  - address increments;
  - the next word is fetched in that same edge;
  - the throttle decision picks the next state.
  - Back-to-back beats are allowed.
- Valid is never retracted: once wr_en=1, out and wr_en stay stable until the beat is accepted.
- GAP: wr_en=0 and out is held.
  - Mode 1 leaves GAP after GAP_LEN cycles.
  - Mode 2 leaves GAP on the first cycle where lfsr[7:0] < DUTY.
- Throttle decision:
  - Mode 0: always PRESENT.
  - Mode 1: GAP after every GAP_PERIOD-th accepted beat (beat counter wraps at GAP_PERIOD).
  - Mode 2: PRESENT if lfsr[7:0] < DUTY, otherwise GAP.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advanced every cycle outside HOLD.
- EOF on the first byte of a word:
  - eof_seen=1.
  - EOF_MODE 0: go to DONE; no further beats.
  - EOF_MODE 1: $rewind, then refetch. If the file is empty after the rewind, go to DONE.
- EOF mid-word: the remaining bytes are 8'h00, the padded word is still sent, eof_seen=1, and the next fetch follows the rules above.
- Accepted beat with address+1 == END_ADDRESS: DONE on that edge.
- DONE: wr_en=0, done=1, out holds its last value. Only reset exits DONE.

## Timing
- Reset (asynchronous, immediate) sets:
  - wr_en=0, out=0, address=0, done=0, eof_seen=0;
  - state=HOLD, reset counter=0, LFSR=LFSR_SEED;
  - $rewind of the file. On the next run the driver replays from byte 0.
- Reset mid-beat: wr_en drops in the same delta. No beat is counted.
- Latency: in mode 0, the first wr_en=1 appears after the (RESET_TIME+2)th rising edge following deassertion (RESET_TIME edges in HOLD, 1 in LOAD, 1 to register).
- Throughput: mode 0 with ready=1 gives one beat per cycle. Mode 1 gives GAP_PERIOD beats per GAP_PERIOD+GAP_LEN cycles.
- ready may toggle freely. Only edges with wr_en=1 & ready=1 count.
- address is 32-bit unsigned and never wraps; END_ADDRESS bounds it.

## Test plan
- WIDTH=32, BIG_ENDIAN=0, file bytes 00..09, ready=1 → beats 32'h03020100, 32'h07060504, 32'h00000908 (padded); then done=1, eof_seen=1, address=3, wr_en=0.
- Same file, BIG_ENDIAN=1 → first beat 32'h00010203, third beat 32'h08090000.
- THROTTLE_MODE=1, GAP_PERIOD=2, GAP_LEN=3, ready=1, 16-byte file, WIDTH=8 → repeating pattern of wr_en high 2 cycles, low 3 cycles; 16 beats total; out stable during gaps.
- ready toggled with pattern 1,0,0,1 under THROTTLE_MODE=0 → wr_en held high with out unchanged across ready=0 cycles; address increments only on ready=1 edges.
- EOF_MODE=1, END_ADDRESS=7, WIDTH=8, 3-byte file AA BB CC → beats AA BB CC AA BB CC AA; done=1 at address=7; eof_seen=1.
- Reset asserted at beat 2 of a 4-beat run → wr_en=0 and address=0 immediately; after release, the stream restarts at file byte 0 with RESET_TIME+2 latency.
